// File: rtl/arr_pkg.sv
// Shared constants, arbiter state type and address range helper for the
// array-memory port arbiter.
package arr_pkg;

  localparam int ARR_ADDR_W = 10;
  localparam int ARR_DATA_W = 64;
  localparam int ARR_DEPTH  = 1000;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic logic in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-one finder: scans ptr+1, ptr+2, ... (mod N)
// and returns the first set bit as one-hot plus its index.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
)(
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int unsigned j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && valid[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/arr_port_arbiter.sv
// Round-robin arbiter sharing one single-port array memory between N_REQ
// requesters, with lock for RMW bursts and out-of-range drop/error.
module arr_port_arbiter
  import arr_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = ARR_ADDR_W,
  parameter int DATA_W = ARR_DATA_W,
  parameter int DEPTH  = ARR_DEPTH
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ-1:0]          req_lock,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int IW = $clog2(N_REQ);

  arb_state_e                    state_q, state_d;
  logic [IW-1:0]                 owner_q, owner_d;
  logic [IW-1:0]                 rr_ptr_q, rr_ptr_d;
  logic                          rsp_pending_q, rsp_pending_d;
  logic [IW-1:0]                 rsp_owner_q, rsp_owner_d;
  logic                          rsp_oor_q, rsp_oor_d;

  logic [N_REQ-1:0][ADDR_W-1:0]  addr_a;
  logic [N_REQ-1:0][DATA_W-1:0]  wdata_a;
  logic [N_REQ-1:0]              elig, gnt;
  logic [IW-1:0]                 gidx;
  logic                          pick_any, gnt_any;
  logic [ADDR_W-1:0]             g_addr;
  logic [DATA_W-1:0]             g_wdata;
  logic                          g_we, g_lock, g_inr;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  // While locked, everyone but the owner is masked, even if the owner is idle.
  always_comb begin
    elig = req_valid;
    if (state_q == ARB_LOCKED) elig = req_valid & (N_REQ'(1) << owner_q);
  end

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .valid (elig),
    .ptr   (rr_ptr_q),
    .gnt   (gnt),
    .idx   (gidx),
    .any   (pick_any)
  );

  assign gnt_any   = pick_any & rst_n;
  assign req_ready = gnt & {N_REQ{rst_n}};

  always_comb begin
    g_addr  = addr_a[gidx];
    g_wdata = wdata_a[gidx];
    g_we    = req_we[gidx];
    g_lock  = req_lock[gidx];
    g_inr   = in_range(32'(g_addr), DEPTH);
  end

  always_comb begin
    mem_we    = gnt_any & g_we & g_inr;
    mem_addr  = gnt_any ? g_addr  : '0;
    mem_wdata = gnt_any ? g_wdata : '0;
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    rsp_pending_d = gnt_any & ~g_we;
    rsp_owner_d   = gidx;
    rsp_oor_d     = ~g_inr;
    if (gnt_any) begin
      rr_ptr_d = gidx;
      owner_d  = gidx;
      state_d  = g_lock ? ARB_LOCKED : ARB_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARB_IDLE;
      owner_q       <= '0;
      rr_ptr_q      <= IW'(N_REQ - 1);
      rsp_pending_q <= 1'b0;
      rsp_owner_q   <= '0;
      rsp_oor_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      rsp_pending_q <= rsp_pending_d;
      rsp_owner_q   <= rsp_owner_d;
      rsp_oor_q     <= rsp_oor_d;
    end
  end

  // Out-of-range reads answer with zero data so nothing stale leaks out.
  always_comb begin
    rsp_valid = rsp_pending_q ? (N_REQ'(1) << rsp_owner_q) : '0;
    rsp_err   = rsp_pending_q & rsp_oor_q;
    rsp_rdata = (rsp_pending_q && !rsp_oor_q) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_arr_port_arbiter.sv
// Directed bench for arr_port_arbiter with a behavioural 1-cycle-read memory.
module tb_arr_port_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid, req_we, req_lock, req_ready, rsp_valid;
  logic [19:0]  req_addr;
  logic [127:0] req_wdata;
  logic         rsp_err, mem_we;
  logic [63:0]  rsp_rdata, mem_wdata, mem_rdata;
  logic [9:0]   mem_addr;
  logic         mem_init = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] mem [0:1023];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 64'h1000 + 64'(i);
      mem_rdata <= '0;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  arr_port_arbiter #(.N_REQ(2), .ADDR_W(10), .DATA_W(64), .DEPTH(1000)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                     input logic [9:0] a0, input logic [9:0] a1,
                     input logic [63:0] d0, input logic [63:0] d1);
    req_valid = v;
    req_we    = we;
    req_lock  = lk;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  // Sample mid-cycle: ready/mem for this cycle, rsp for the previous beat.
  task automatic smp(input string tag, input logic [1:0] rdy, input logic mwe, input logic [1:0] rv);
    @(negedge clk);
    chk({tag, ".ready"}, 64'(req_ready), 64'(rdy));
    chk({tag, ".mem_we"}, 64'(mem_we), 64'(mwe));
    chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(rv));
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drv(2'b11, 2'b00, 2'b00, 10'd5, 10'd5, 64'd0, 64'd0);
    repeat (3) adv();
    smp("rst", 2'b00, 1'b0, 2'b00);
    chk("rst.rsp_err", 64'(rsp_err), 64'd0);
    mem_init = 1'b0;
    adv();
    rst_n = 1'b1;

    // Round robin from rr_ptr=1: requester 0 first, then alternate.
    smp("t1c0", 2'b01, 1'b0, 2'b00);
    chk("t1c0.mem_addr", 64'(mem_addr), 64'd5);
    adv();
    smp("t1c1", 2'b10, 1'b0, 2'b01);
    chk("t1c1.rdata", rsp_rdata, 64'h1005);
    chk("t1c1.err", 64'(rsp_err), 64'd0);
    adv();
    smp("t1c2", 2'b01, 1'b0, 2'b10);
    chk("t1c2.rdata", rsp_rdata, 64'h1005);
    adv();

    // Write then read of the same address returns new data.
    drv(2'b01, 2'b01, 2'b00, 10'd7, 10'd0, 64'd42, 64'd0);
    smp("t2w", 2'b01, 1'b1, 2'b01);
    chk("t2w.mem_addr", 64'(mem_addr), 64'd7);
    chk("t2w.mem_wdata", mem_wdata, 64'd42);
    adv();
    drv(2'b10, 2'b00, 2'b00, 10'd0, 10'd7, 64'd0, 64'd0);
    smp("t2r", 2'b10, 1'b0, 2'b00);
    adv();
    drv(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 64'd0, 64'd0);
    smp("t2rsp", 2'b00, 1'b0, 2'b10);
    chk("t2rsp.rdata", rsp_rdata, 64'd42);
    chk("t2rsp.mem_addr", 64'(mem_addr), 64'd0);
    adv();

    // Move rr_ptr to 0 so requester 1 wins the next contested grant.
    drv(2'b01, 2'b00, 2'b00, 10'd5, 10'd5, 64'd0, 64'd0);
    smp("t3pre", 2'b01, 1'b0, 2'b00);
    adv();
    drv(2'b11, 2'b00, 2'b10, 10'd5, 10'd6, 64'd0, 64'd0);
    smp("t3l1", 2'b10, 1'b0, 2'b01);
    adv();
    smp("t3l2", 2'b10, 1'b0, 2'b10);
    adv();
    drv(2'b11, 2'b00, 2'b00, 10'd5, 10'd6, 64'd0, 64'd0);
    smp("t3l3", 2'b10, 1'b0, 2'b10);
    adv();
    smp("t3g0", 2'b01, 1'b0, 2'b10);
    chk("t3g0.rdata", rsp_rdata, 64'h1006);
    adv();

    // Lock held while the owner is idle; others stall until a lock=0 beat.
    drv(2'b10, 2'b00, 2'b10, 10'd5, 10'd6, 64'd0, 64'd0);
    smp("t3b1", 2'b10, 1'b0, 2'b01);
    adv();
    drv(2'b01, 2'b00, 2'b00, 10'd5, 10'd6, 64'd0, 64'd0);
    smp("t3idle0", 2'b00, 1'b0, 2'b10);
    adv();
    smp("t3idle1", 2'b00, 1'b0, 2'b00);
    adv();
    drv(2'b11, 2'b00, 2'b00, 10'd5, 10'd6, 64'd0, 64'd0);
    smp("t3rel", 2'b10, 1'b0, 2'b00);
    adv();
    drv(2'b01, 2'b00, 2'b00, 10'd5, 10'd6, 64'd0, 64'd0);
    smp("t3after", 2'b01, 1'b0, 2'b10);
    adv();

    // Range boundary: 999 in range, 1000 and 1023 out of range.
    drv(2'b01, 2'b01, 2'b00, 10'd999, 10'd0, 64'h99, 64'd0);
    smp("t4w999", 2'b01, 1'b1, 2'b01);
    adv();
    drv(2'b01, 2'b01, 2'b00, 10'd1000, 10'd0, 64'h77, 64'd0);
    smp("t4w1000", 2'b01, 1'b0, 2'b00);
    adv();
    drv(2'b01, 2'b00, 2'b00, 10'd1023, 10'd0, 64'd0, 64'd0);
    smp("t4r1023", 2'b01, 1'b0, 2'b00);
    adv();
    drv(2'b01, 2'b00, 2'b00, 10'd999, 10'd0, 64'd0, 64'd0);
    smp("t4oor", 2'b01, 1'b0, 2'b01);
    chk("t4oor.err", 64'(rsp_err), 64'd1);
    chk("t4oor.rdata", rsp_rdata, 64'd0);
    adv();
    drv(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 64'd0, 64'd0);
    smp("t4r999", 2'b00, 1'b0, 2'b01);
    chk("t4r999.err", 64'(rsp_err), 64'd0);
    chk("t4r999.rdata", rsp_rdata, 64'h99);
    adv();

    // Reset while requester 1 holds the lock and its read is in flight.
    drv(2'b10, 2'b00, 2'b10, 10'd0, 10'd5, 64'd0, 64'd0);
    smp("t5lock", 2'b10, 1'b0, 2'b00);
    adv();
    rst_n = 1'b0;
    drv(2'b11, 2'b11, 2'b00, 10'd5, 10'd5, 64'd1, 64'd2);
    smp("t5rst", 2'b00, 1'b0, 2'b00);
    chk("t5rst.err", 64'(rsp_err), 64'd0);
    adv();
    rst_n = 1'b1;
    drv(2'b11, 2'b00, 2'b00, 10'd5, 10'd5, 64'd0, 64'd0);
    smp("t5post0", 2'b01, 1'b0, 2'b00);
    adv();
    smp("t5post1", 2'b10, 1'b0, 2'b01);
    adv();

    // Idle stretch: no grants, and rr_ptr (=1) survives.
    drv(2'b00, 2'b11, 2'b11, 10'd5, 10'd5, 64'd0, 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6idle.ready", 64'(req_ready), 64'd0);
      chk("t6idle.mem_we", 64'(mem_we), 64'd0);
      adv();
    end
    drv(2'b11, 2'b00, 2'b00, 10'd5, 10'd5, 64'd0, 64'd0);
    smp("t6next", 2'b01, 1'b0, 2'b00);
    adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
